// File: rtl/pwm_fade_if.sv
// pwm_fade_if: target handshake between command logic and pwm_fade_ctrl
interface pwm_fade_if #(parameter int data_size = 3) ();
  logic [data_size:0] tgt;
  logic               tgt_valid;
  logic               tgt_ready;
  modport master (output tgt, output tgt_valid, input tgt_ready);
  modport slave (input tgt, input tgt_valid, output tgt_ready);
endinterface

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps pwm rate toward accepted targets, one LSB per period boundary; PWM_FADE_DWELL_EN adds per-step dwell periods
module pwm_fade_ctrl #(
  parameter int data_size = 3,
  parameter int dwell_w = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_fade_if.slave          req,
`ifdef PWM_FADE_DWELL_EN
  input  logic [dwell_w-1:0] dwell,
`endif
  output logic [data_size:0] rate,
  output logic               period_start,
  output logic               busy,
  output logic               done
);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t             state;
  logic [data_size:0] pcnt;
  logic [data_size:0] tgt_q;
  logic [data_size:0] rate_nxt;
  logic               ready_q;
  logic               boundary;
`ifdef PWM_FADE_DWELL_EN
  logic [dwell_w-1:0] dwell_q;
  logic [dwell_w-1:0] dcnt;
`endif
  assign req.tgt_ready = ready_q;
  assign boundary = &pcnt;
  // one LSB toward the latched target, never wrapping since target bounds it
  always_comb rate_nxt = (tgt_q > rate) ? rate + 1'b1 : rate - 1'b1;
  // free-running period counter; strobe is registered so it coincides with pcnt==0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcnt <= '0;
      period_start <= 1'b0;
    end else begin
      pcnt <= pcnt + 1'b1;
      period_start <= boundary;
    end
  // accept a target in IDLE, then step rate on boundary edges until it matches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rate <= '0;
      tgt_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ready_q <= 1'b0;
`ifdef PWM_FADE_DWELL_EN
      dwell_q <= '0;
      dcnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        ready_q <= 1'b1;
        if (req.tgt_valid && ready_q) begin
          tgt_q <= req.tgt;
`ifdef PWM_FADE_DWELL_EN
          dwell_q <= dwell;
          dcnt <= dwell;
`endif
          if (req.tgt == rate) done <= 1'b1;
          else begin
            state <= RAMP;
            busy <= 1'b1;
            ready_q <= 1'b0;
          end
        end
      end else if (boundary) begin
`ifdef PWM_FADE_DWELL_EN
        if (dcnt != '0) dcnt <= dcnt - 1'b1;
        else begin
          dcnt <= dwell_q;
`endif
          rate <= rate_nxt;
          if (rate_nxt == tgt_q) begin
            state <= IDLE;
            busy <= 1'b0;
            ready_q <= 1'b1;
            done <= 1'b1;
          end
`ifdef PWM_FADE_DWELL_EN
        end
`endif
      end
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed and random targets checked against a closed-form ramp timing model
module tb_pwm_fade_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dwell = '0;
  logic [3:0] rate;
  logic       period_start, busy, done;
  int         errors = 0;
  int         checks = 0;
  int         ecount = 0;
  int         mrate = 0;

  pwm_fade_if #(.data_size(3)) req ();

  pwm_fade_ctrl #(.data_size(3), .dwell_w(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
`ifdef PWM_FADE_DWELL_EN
    .dwell(dwell),
`endif
    .rate(rate),
    .period_start(period_start),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one edge; pcnt now equals ecount mod 16, strobe only where it is 0
  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
    chk("period_start", int'(period_start), int'(ecount % 16 == 0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rate"}, int'(rate), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pstart"}, int'(period_start), 0);
    chk({tag, "_ready"}, int'(req.tgt_ready), 0);
  endtask

  // accept target t (optionally when pcnt==p_at), follow the ramp edge by edge;
  // abort>=0 asserts reset once the expected rate reaches that value
  task automatic do_target(input int t, input int dw, input int p_at, input int abort);
    int p, d1, n, total, b, steps, dd, er;
    if (p_at >= 0) while (ecount % 16 != p_at) step();
    chk("ready_before_accept", int'(req.tgt_ready), 1);
`ifdef PWM_FADE_DWELL_EN
    dd = dw;
`else
    dd = 0;
`endif
    dwell = 8'(dw);
    req.tgt = 4'(t);
    req.tgt_valid = 1'b1;
    p = ecount % 16;
    step();
    req.tgt_valid = 1'b0;
    if (t == mrate) begin
      chk("eq_done", int'(done), 1);
      chk("eq_busy", int'(busy), 0);
      chk("eq_rate", int'(rate), mrate);
      chk("eq_ready", int'(req.tgt_ready), 1);
      step();
      chk("eq_done_clear", int'(done), 0);
      return;
    end
    d1 = ((15 - p) % 16 == 0) ? 16 : (15 - p) % 16;
    n = (t > mrate) ? t - mrate : mrate - t;
    total = d1 + 16 * (n * (dd + 1) - 1);
    chk("ramp_busy_start", int'(busy), 1);
    chk("ramp_ready_start", int'(req.tgt_ready), 0);
    for (int i = 1; i <= total; i++) begin
      step();
      b = (i >= d1) ? (i - d1) / 16 + 1 : 0;
      steps = b / (dd + 1);
      er = (t > mrate) ? mrate + steps : mrate - steps;
      chk("ramp_rate", int'(rate), er);
      chk("ramp_busy", int'(busy), int'(i < total));
      chk("ramp_done", int'(done), int'(i == total));
      chk("ramp_ready", int'(req.tgt_ready), int'(i == total));
      if (abort >= 0 && er == abort) begin
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        #2 rst_n = 1'b1;
        req.tgt_valid = 1'b0;
        ecount = 0;
        mrate = 0;
        return;
      end
      req.tgt_valid = (i < total - 1);
      req.tgt = 4'($urandom_range(0, 15));
    end
    mrate = t;
    step();
    chk("ramp_done_clear", int'(done), 0);
    chk("ramp_rate_hold", int'(rate), t);
  endtask

  initial begin
    req.tgt = '0;
    req.tgt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    #3 rst_n = 1'b1;
    chk("ready_pre_edge", int'(req.tgt_ready), 0);
    step();
    chk("ready_first_edge", int'(req.tgt_ready), 1);
    chk("idle_rate", int'(rate), 0);
    repeat (40) begin
      step();
      chk("idle_busy", int'(busy), 0);
    end
    do_target(5, 0, 3, -1);
    do_target(2, 0, 15, -1);
    do_target(2, 0, -1, -1);
`ifdef PWM_FADE_DWELL_EN
    do_target(0, 0, -1, -1);
    do_target(3, 2, -1, -1);
`endif
    do_target(12, 0, -1, 7);
    chk("post_reset_ready", int'(req.tgt_ready), 0);
    step();
    chk("post_reset_ready_edge", int'(req.tgt_ready), 1);
    chk("post_reset_rate", int'(rate), 0);
    for (int k = 0; k < 10; k++)
      do_target(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
